// File: rtl/image_pkg.sv
// image_pkg
//   Shared types and sizing helpers for the LCD image path.
//   loader_state_t   : image_loader FSM states
//   addr_size(w,h)   : pixel address width for a w x h image memory
//   pixels_per_word(p): pixels packed into one 32-bit bridge word
package image_pkg;

   localparam int WORD_BITS = 32;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } loader_state_t;

   function automatic int addr_size(input int w, input int h);
      return $clog2(w * h);
   endfunction

   function automatic int pixels_per_word(input int p);
      return WORD_BITS / p;
   endfunction

endpackage

// File: rtl/pixel_unpacker.sv
// pixel_unpacker
//   Holds one 32-bit word and emits its pixels MSB-first, one per cycle.
//   clk, reset  : clock, synchronous active-high reset
//   load, word  : capture a new word (pixel 0 appears next cycle)
//   flush       : drop whatever is held; wins over load
//   pixel       : current pixel (registered)
//   pixel_valid : pixel holds a live value (registered)
//   last        : current pixel is the final one of the word
module pixel_unpacker
   import image_pkg::*;
#(
   parameter int PIXEL_BIT_COUNT = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load,
   input  logic [31:0]                word,
   input  logic                       flush,
   output logic [PIXEL_BIT_COUNT-1:0] pixel,
   output logic                       pixel_valid,
   output logic                       last
);

   localparam int PPW = pixels_per_word(PIXEL_BIT_COUNT);
   localparam int CW  = $clog2(PPW + 1);

   logic [31:0]   sr;
   logic [CW-1:0] cnt;   // pixels still to emit, including the current one

   assign pixel = sr[31 -: PIXEL_BIT_COUNT];
   assign last  = (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         sr          <= '0;
         cnt         <= '0;
         pixel_valid <= 1'b0;
      end else if (flush) begin
         cnt         <= '0;
         pixel_valid <= 1'b0;
      end else if (load) begin
         // A load may coincide with emitting the last pixel: the new word
         // replaces it directly, giving gap-free output.
         sr          <= word;
         cnt         <= CW'(PPW);
         pixel_valid <= 1'b1;
      end else if (pixel_valid) begin
         sr          <= sr << PIXEL_BIT_COUNT;
         cnt         <= cnt - CW'(1);
         pixel_valid <= (cnt != CW'(1));
      end
   end

endmodule

// File: rtl/image_loader.sv
// image_loader
//   Streams 32-bit words into an image memory write port, one pixel per
//   cycle at sequential addresses 0..MEM_WIDTH*MEM_HEIGHT-1.
//   clk, reset         : clock, synchronous active-high reset
//   start              : begin / restart a load at address 0
//   in_valid/in_ready  : word handshake, in_data pixel 0 in the top bits
//   image_write_*      : registered memory write port
//   busy               : load in progress (video reads suppressed)
//   done               : last load completed, held until start/reset
module image_loader
   import image_pkg::*;
#(
   parameter  int MEM_WIDTH       = 100,
   parameter  int MEM_HEIGHT      = 100,
   parameter  int PIXEL_BIT_COUNT = 32,
   localparam int ADDR_SIZE       = addr_size(MEM_WIDTH, MEM_HEIGHT)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_data,
   output logic                       image_write_en,
   output logic [ADDR_SIZE-1:0]       image_write_addr,
   output logic [PIXEL_BIT_COUNT-1:0] image_write_data,
   output logic                       busy,
   output logic                       done
);

   localparam int MEM_SIZE = MEM_WIDTH * MEM_HEIGHT;

   generate
      if (!(PIXEL_BIT_COUNT == 1 || PIXEL_BIT_COUNT == 2 || PIXEL_BIT_COUNT == 4 ||
            PIXEL_BIT_COUNT == 8 || PIXEL_BIT_COUNT == 16 || PIXEL_BIT_COUNT == 32))
      begin : g_bad_pixel_bits
         $error("image_loader: PIXEL_BIT_COUNT must be 1, 2, 4, 8, 16 or 32");
      end
   endgenerate

   loader_state_t        state, state_nxt;
   logic [ADDR_SIZE-1:0] addr;
   logic                 pix_valid, pix_last, terminal, accept;

   // The unpacker's registers are the write port: its current pixel is the
   // write happening this cycle at addr.
   assign terminal = pix_valid && (addr == ADDR_SIZE'(MEM_SIZE - 1));
   assign in_ready = (state == LOAD) && !start && (!pix_valid || pix_last);
   assign accept   = in_valid && in_ready;

   pixel_unpacker #(
      .PIXEL_BIT_COUNT(PIXEL_BIT_COUNT)
   ) u_unpacker (
      .clk         (clk),
      .reset       (reset),
      .load        (accept),
      .word        (in_data),
      .flush       (start || terminal),
      .pixel       (image_write_data),
      .pixel_valid (pix_valid),
      .last        (pix_last)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = LOAD;
         LOAD: begin
            if (start)         state_nxt = LOAD;
            else if (terminal) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || start)            addr <= '0;
      else if (pix_valid && !terminal) addr <= addr + ADDR_SIZE'(1);
   end

   assign image_write_en   = pix_valid;
   assign image_write_addr = addr;
   assign busy             = (state == LOAD);
   assign done             = (state == DONE);

endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader
//   Drives five image_loader configurations from shared inputs and checks
//   the selected one each cycle against a queue-based reference model.
module tb_image_loader;

   logic        clk = 1'b0;
   logic        reset, start, in_valid;
   logic [31:0] in_data;

   logic rdy[5], en[5], bsy[5], dn[5];
   logic [2:0] a0;  logic [7:0]  d0;   // 4x2,  8bpp
   logic [1:0] a1;  logic [31:0] d1;   // 2x2,  32bpp
   logic [1:0] a2;  logic [7:0]  d2;   // 3x1,  8bpp
   logic [4:0] a3;  logic        d3;   // 32x1, 1bpp
   logic [4:0] a4;  logic [3:0]  d4;   // 7x3,  4bpp

   int CW[5] = '{4, 2, 3, 32, 7};
   int CH[5] = '{2, 2, 1, 1, 3};
   int CP[5] = '{8, 32, 8, 1, 4};

   int n_cmp = 0, n_fail = 0;
   int cfg = 0;

   always #5 clk = ~clk;

   image_loader #(.MEM_WIDTH(4), .MEM_HEIGHT(2), .PIXEL_BIT_COUNT(8)) u0 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_data(in_data), .image_write_en(en[0]), .image_write_addr(a0),
      .image_write_data(d0), .busy(bsy[0]), .done(dn[0]));
   image_loader #(.MEM_WIDTH(2), .MEM_HEIGHT(2), .PIXEL_BIT_COUNT(32)) u1 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_data(in_data), .image_write_en(en[1]), .image_write_addr(a1),
      .image_write_data(d1), .busy(bsy[1]), .done(dn[1]));
   image_loader #(.MEM_WIDTH(3), .MEM_HEIGHT(1), .PIXEL_BIT_COUNT(8)) u2 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_data(in_data), .image_write_en(en[2]), .image_write_addr(a2),
      .image_write_data(d2), .busy(bsy[2]), .done(dn[2]));
   image_loader #(.MEM_WIDTH(32), .MEM_HEIGHT(1), .PIXEL_BIT_COUNT(1)) u3 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy[3]),
      .in_data(in_data), .image_write_en(en[3]), .image_write_addr(a3),
      .image_write_data(d3), .busy(bsy[3]), .done(dn[3]));
   image_loader #(.MEM_WIDTH(7), .MEM_HEIGHT(3), .PIXEL_BIT_COUNT(4)) u4 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy[4]),
      .in_data(in_data), .image_write_en(en[4]), .image_write_addr(a4),
      .image_write_data(d4), .busy(bsy[4]), .done(dn[4]));

   // ---------------- reference model ----------------
   // m_st: 0 idle, 1 loading, 2 finished. m_q holds pixels still owed to
   // memory; its head is the write visible this cycle at m_addr.
   int          m_st = 0;
   int          m_addr = 0;
   logic [31:0] m_q[$];

   function automatic logic [31:0] pixel_of(input logic [31:0] w, input int k, input int p);
      longint unsigned lw = 64'(w);
      return 32'((lw >> (32 - (k + 1) * p)) & ((64'd1 << p) - 1));
   endfunction

   // {en, in_ready, busy, done, addr, data}; addr/data only meaningful with en
   function automatic logic [67:0] model_exp();
      logic        we, r;
      logic [31:0] a, d;
      we = (m_q.size() > 0);
      r  = (m_st == 1) && !start && (m_q.size() <= 1);
      a  = we ? 32'(m_addr) : 32'd0;
      d  = we ? m_q[0] : 32'd0;
      return {we, r, (m_st == 1), (m_st == 2), a, d};
   endfunction

   task automatic model_clock();
      int ms  = CW[cfg] * CH[cfg];
      int p   = CP[cfg];
      bit acc = in_valid && (m_st == 1) && !start && (m_q.size() <= 1);
      if (reset) begin
         m_st = 0; m_q.delete(); m_addr = 0;
      end else if (start) begin
         m_st = 1; m_q.delete(); m_addr = 0;
      end else if (m_st == 1) begin
         if (m_q.size() > 0 && m_addr == ms - 1) begin
            m_st = 2; m_q.delete();
         end else begin
            if (m_q.size() > 0) begin
               void'(m_q.pop_front());
               m_addr++;
            end
            if (acc)
               for (int k = 0; k < 32 / p; k++) m_q.push_back(pixel_of(in_data, k, p));
         end
      end
   endtask

   function automatic logic [67:0] get_obs(input bit raw);
      logic        e, r, b, f;
      logic [31:0] a, d;
      e = en[cfg]; r = rdy[cfg]; b = bsy[cfg]; f = dn[cfg];
      case (cfg)
         0:       begin a = 32'(a0); d = 32'(d0); end
         1:       begin a = 32'(a1); d = d1;      end
         2:       begin a = 32'(a2); d = 32'(d2); end
         3:       begin a = 32'(a3); d = 32'(d3); end
         default: begin a = 32'(a4); d = 32'(d4); end
      endcase
      if (!raw && e !== 1'b1) begin a = '0; d = '0; end
      return {e, r, b, f, a, d};
   endfunction

   // Apply inputs for the current cycle and sample pre-edge outputs.
   task automatic drive(input logic s, input logic v, input logic [31:0] d,
                        output logic [67:0] obs, output logic [67:0] exp);
      start = s; in_valid = v; in_data = d;
      #1;
      exp = model_exp();
      obs = get_obs(1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic do_reset(input int c);
      cfg = c;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      tick();
      reset = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [67:0] obs;
      for (int c = 0; c < 5; c++) begin
         do_reset(c);
         #1;
         obs = get_obs(1'b1);
         n_cmp++;
         if (obs !== 68'd0) begin
            n_fail++;
            $display("FAIL reset cfg%0d got %h want 0", c, obs);
         end
      end
   endtask

   // Words are offered until the model says they were taken.
   task automatic run_words(input string name, input int c, input int cycles,
                            input logic [31:0] words[$], input bit toggle);
      logic [67:0] obs, exp;
      int wi = 0;
      logic v;
      do_reset(c);
      for (int i = 0; i < cycles; i++) begin
         v = (i > 0) && (wi < words.size()) && (!toggle || i[0]);
         drive(i == 0, v, (wi < words.size()) ? words[wi] : 32'hFFFF_FFFF, obs, exp);
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d got %h want %h", name, i, obs, exp);
         end
         if (v && exp[66]) wi++;
         tick();
      end
   endtask

   task automatic test_8bpp_two_words();
      logic [31:0] w[$] = '{32'h0011_2233, 32'h4455_6677};
      run_words("8bpp_4x2", 0, 14, w, 1'b0);
   endtask

   task automatic test_valid_toggle();
      logic [31:0] w[$] = '{32'hCAFE_0001, 32'h1234_5678, 32'h8000_0000, 32'h0000_00FF};
      run_words("32bpp_toggle", 1, 14, w, 1'b1);
   endtask

   task automatic test_partial_word();
      logic [31:0] w[$] = '{32'hAABB_CCDD, 32'h1122_3344};
      run_words("8bpp_partial", 2, 10, w, 1'b0);
   endtask

   task automatic test_1bpp();
      logic [31:0] w[$] = '{32'h8000_0001};
      run_words("1bpp_32x1", 3, 40, w, 1'b0);
   endtask

   task automatic test_restart();
      logic [67:0] obs, exp;
      logic s, v;
      logic [31:0] d;
      do_reset(0);
      for (int i = 0; i < 16; i++) begin
         s = (i == 0) || (i == 4);   // i==4 lands on pixel 2 of the first word
         v = (i == 1) || (i >= 4);
         d = (i == 1) ? 32'hA1A2_A3A4 : (i == 4) ? 32'hB1B2_B3B4 : 32'hC0C1_C2C3 + 32'(i);
         drive(s, v, d, obs, exp);
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL restart cyc %0d got %h want %h", i, obs, exp);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_load();
      logic [67:0] obs, exp;
      do_reset(4);
      for (int i = 0; i < 24; i++) begin
         if (i == 6) reset = 1'b1;
         drive(i == 0 || i == 18, i != 0, $urandom, obs, exp);
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_mid cyc %0d got %h want %h", i, obs, exp);
         end
         tick();
         if (i == 6) begin
            reset = 1'b0;
            #1;
            obs = get_obs(1'b1);
            n_cmp++;
            if (obs !== 68'd0) begin
               n_fail++;
               $display("FAIL reset_mid_zero got %h want 0", obs);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [67:0] obs, exp;
      for (int c = 0; c < 5; c++) begin
         do_reset(c);
         for (int i = 0; i < 300; i++) begin
            drive((i == 0) || ($urandom_range(0, 39) == 0), $urandom_range(0, 3) != 0,
                  $urandom, obs, exp);
            n_cmp++;
            if (obs !== exp) begin
               n_fail++;
               $display("FAIL random cfg%0d cyc %0d got %h want %h", c, i, obs, exp);
            end
            tick();
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      @(negedge clk);
      test_reset();
      test_8bpp_two_words();
      test_valid_toggle();
      test_partial_word();
      test_restart();
      test_reset_mid_load();
      test_1bpp();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/image_loader.md
# image_loader

Streaming writer for the LCD image memories. Accepts 32-bit words from the data-slot bridge path over a valid/ready handshake, unpacks each word into `PIXEL_BIT_COUNT`-bit pixels, and drives the memory's `image_write_en` / `image_write_addr` / `image_write_data` port with sequential addresses from 0 to `MEM_WIDTH*MEM_HEIGHT-1`. Sits between the bridge word FIFO and one `image_write_*` port. Reports `busy` so the video side knows reads are suppressed while writes are in progress.

## Interface
- `MEM_WIDTH`, 100, image width in pixels.
- `MEM_HEIGHT`, 100, image height in pixels.
- `PIXEL_BIT_COUNT`, 32, bits per pixel. Legal values are 1, 2, 4, 8, 16 and 32; other values fail elaboration.

- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins or restarts a load at address 0.
- `in_valid`  in  1  `in_data` holds a word.
- `in_ready`  out  1  loader accepts the word this cycle.
- `in_data`  in  32  packed pixels. Pixel 0 occupies bits `[31:32-PIXEL_BIT_COUNT]`.
- `image_write_en`  out  1  write strobe to the memory.
- `image_write_addr`  out  `ADDR_SIZE`  pixel address, where `ADDR_SIZE = $clog2(MEM_WIDTH*MEM_HEIGHT)`.
- `image_write_data`  out  `PIXEL_BIT_COUNT`  pixel value.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed. Held until the next `start` or `reset`.

## Operation
- Derived constants:
  - `MEM_SIZE = MEM_WIDTH*MEM_HEIGHT`.
  - `PIXELS_PER_WORD (PPW) = 32/PIXEL_BIT_COUNT`.
- States:
  - **IDLE**: entered on reset.
  - **LOAD**: transfer in progress.
  - **DONE**: load complete.
- Transitions:
  - IDLE or DONE, `start` → LOAD. Write address counter is set to 0 and the unpacker is emptied.
  - LOAD, `start` → LOAD (restart). Address is set to 0, any partially emitted word is discarded, and the `in_valid` word offered in that cycle is not accepted.
  - LOAD, write to address `MEM_SIZE-1` issued → DONE. Any remaining pixels of that word are discarded.
- Ready rule:
  - `in_ready = (state==LOAD) && !start && (unpacker empty || unpacker emitting its last pixel this cycle)`.
  - `in_ready` never depends on `in_valid`.
- Unpacker:
  - An accepted word loads a shift register holding PPW pixels.
  - One pixel is emitted per cycle, MSB-first.
  - The address increments by 1 after every write.
  - No write occurs when the unpacker is empty.
- Outputs:
  - `busy = (state==LOAD)`.
  - `done = (state==DONE)`.
- Address width: the address counter is `ADDR_SIZE` bits. Terminal compare is against `MEM_SIZE-1`, so the address never wraps.
- In IDLE and DONE, `in_ready` is 0. Words offered there stay unconsumed.
- Reset mid-load: all state returns to IDLE. No further writes occur.

## Timing
- Reset values: `in_ready`, `image_write_en`, `image_write_addr`, `image_write_data`, `busy` and `done` are all 0.
- `image_write_*` outputs are registered.
  - A word accepted in cycle t produces pixel k with `image_write_en=1` in cycle t+1+k, for k = 0..PPW-1.
- Throughput: with `in_valid` held high, one word is accepted every PPW cycles and `image_write_en` stays high continuously.
  - With PPW=1, a word is accepted every cycle.
- `start` in cycle t: `busy=1` and `done=0` from t+1. The first word can be accepted at t+1.
- Last write at cycle t: `busy=0` and `done=1` from t+1. `image_write_en=0` at t+1.
- Addresses are strictly sequential with no gaps. Stalls on `in_valid` only insert idle cycles with `image_write_en=0`.

## Structure
- Shared package `image_pkg`:
  - `loader_state_t` enum (IDLE, LOAD, DONE).
  - Functions `addr_size(w,h)` and `pixels_per_word(p)`, also used to size `image_memory` ports.
- One sub-module, `pixel_unpacker`:
  - Parameter: `PIXEL_BIT_COUNT`.
  - Ports: `load`, `word[31:0]`, `flush`, `pixel`, `pixel_valid`, `last`.
  - Handles the shift register and count. The top level owns the FSM, address counter and handshake.

## Test plan
- **8bpp, 4×2 image, 2 words.** `start`, then `0x00112233` and `0x44556677` back-to-back. Writes at addresses 0..7 with data 00,11,22,33,44,55,66,77 on consecutive cycles. `done=1` the cycle after address 7.
- **32bpp, 2×2 image, `in_valid` toggling every other cycle.** Four writes at addresses 0..3 with `image_write_en` gaps matching the valid gaps. `in_ready=1` throughout LOAD.
- **8bpp, 3×1 image, partial last word.** One word `0xAABBCCDD` gives writes of AA, BB, CC at addresses 0..2. `0xDD` is never written. Second word is not accepted: `in_ready=0` and `done=1`.
- **Restart mid-load.** `start` pulsed during pixel 2 of word 0. The offered word is not accepted. The next accepted word writes from address 0. No write to the discarded pixels follows.
- **Reset mid-load.** `reset` asserted during LOAD. The next cycle shows all outputs 0 and state IDLE. `in_valid` then has no effect until `start`.
- **1bpp, 32×1 image.** One word `0x80000001` gives data 1 at addresses 0 and 31, 0 elsewhere. `done` is asserted 33 cycles after acceptance.
